r_type_multicycle_controller: RTL and testbench
===============================================

R_TYPE_MULTICYCLE_CONTROLLER -- requirements
Module: r_type_multicycle_controller

Interface
REQ-001 The block SHALL have a parameter TIMEOUT, default 15, giving the maximum wait cycles for mem_ready per fetch (legal range 1..255).
REQ-002 The block SHALL have a parameter CNT_W, default 16, giving the width of the retired-instruction counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin execution when idle.
REQ-006 The block SHALL have port stop, input, 1 bit: request return to IDLE after the current instruction.
REQ-007 The block SHALL have port mem_ready, input, 1 bit: the instruction word is valid this cycle.
REQ-008 The block SHALL have port opcode, input, 6 bits: instruction[31:26].
REQ-009 The block SHALL have port function_code, input, 6 bits: instruction[5:0].
REQ-010 The block SHALL have port mem_req, output, 1 bit: instruction fetch request.
REQ-011 The block SHALL have ports ir_write, pc_write, alu_out_write and reg_write, outputs, 1 bit each: single-cycle datapath enables.
REQ-012 The block SHALL have port select_bits_ALU, output, 3 bits: ALU operation select.
REQ-013 The block SHALL have ports busy, halted and error, outputs, 1 bit each: status.
REQ-014 The block SHALL have port err_code, output, 2 bits: 00 none, 01 illegal instruction, 10 fetch timeout.
REQ-015 The block SHALL have port instr_count, output, CNT_W bits: number of retired instructions.
REQ-016 The block SHALL have port state, output, 3 bits: IDLE 000, FETCH 001, DECODE 010, EXECUTE 011, WRITEBACK 100, HALT 101, ERROR 110.

Function
REQ-017 IDLE: all enables are 0 and busy=0; start=1 moves the FSM to FETCH.
REQ-018 FETCH: mem_req=1 and busy=1; on mem_ready=1, ir_write=1 and pc_write=1 for that cycle only, the wait counter clears, and the FSM moves to DECODE.
REQ-019 FETCH: the wait counter increments each cycle mem_ready=0; when it reaches TIMEOUT, the FSM moves to ERROR with err_code=10.
REQ-020 DECODE: the block latches function_code; opcode!=000000 or an unlisted function_code moves the FSM to ERROR with err_code=01.
REQ-021 DECODE: function_code=001100 (syscall) moves the FSM to HALT and sets halted=1; instr_count does not increment.
REQ-022 Legal function_code to select_bits_ALU mapping: add 100000->010, sub 100010->100, and 100100->000, or 100101->001, nor 100111->111, slt 101010->011, sll 000000->110, srl 000010->101.
REQ-023 EXECUTE (one cycle): select_bits_ALU is driven from the latched function code and alu_out_write=1.
REQ-024 WRITEBACK (one cycle): select_bits_ALU is held, reg_write=1, and instr_count increments modulo 2^CNT_W (all-ones wraps to 0).
REQ-025 After WRITEBACK, the FSM goes to IDLE if stop is pending, otherwise to FETCH.
REQ-026 stop sampled high in any non-IDLE state sets the stop-pending flag; the flag clears on entry to IDLE.
REQ-027 stop never aborts an in-flight instruction; start and stop high together in IDLE means start wins and stop is pending.
REQ-028 select_bits_ALU is 000 outside EXECUTE and WRITEBACK.
REQ-029 HALT and ERROR are sticky: all enables are 0 and busy=0, and start and stop are ignored; only reset leaves these states.
REQ-030 Every enable is a one-cycle pulse; no two of ir_write, alu_out_write and reg_write are ever high in the same cycle.

Reset
REQ-031 reset=1 at a clock edge, in any state including mid-fetch, forces: state=IDLE; all enables 0; select_bits_ALU=000; busy, halted and error 0; err_code=00; instr_count=0; the wait counter and stop-pending flag cleared.
REQ-032 reset takes priority over start, stop and mem_ready in the same cycle.

Verification
REQ-033 Scenario: start, then add (opcode 0, funct 100000) with mem_ready in the first FETCH cycle -> states 001,010,011,100,001; select_bits_ALU=010 in EXECUTE; reg_write is a single pulse; instr_count=1.
REQ-034 Scenario: all eight legal functs in sequence, then syscall -> each select_bits_ALU matches REQ-022; halted=1; instr_count=8; a later start has no effect.
REQ-035 Scenario: opcode=100011 -> error=1, err_code=01, reg_write never asserted, instr_count unchanged.
REQ-036 Scenario: mem_ready held 0 with TIMEOUT=15 -> ERROR entered exactly 15 cycles after FETCH entry, err_code=10.
REQ-037 Scenario: stop pulsed during EXECUTE -> WRITEBACK completes, instr_count increments, then IDLE with busy=0.
REQ-038 Scenario: CNT_W=4, 16 retired instructions -> instr_count wraps to 0; a reset during FETCH -> IDLE next cycle with all outputs at their reset values.

Source files
------------

// File: rtl/r_type_multicycle_controller.sv
// Multicycle controller for R-type instructions.
// Sequences FETCH -> DECODE -> EXECUTE -> WRITEBACK per instruction, decodes the
// function field to an ALU select, counts retired instructions and traps to sticky
// HALT (syscall) or ERROR (illegal instruction, fetch timeout) states.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, stop           run control (stop takes effect after the current instruction)
//   mem_ready             instruction word valid this cycle
//   opcode, function_code instruction[31:26] and instruction[5:0]
//   mem_req               instruction fetch request
//   ir_write, pc_write    capture instruction / advance PC (same cycle as mem_ready)
//   alu_out_write         ALU output register enable (EXECUTE)
//   reg_write             register file write enable (WRITEBACK)
//   select_bits_ALU       ALU operation select
//   busy, halted, error   status flags; err_code 01 illegal, 10 fetch timeout
//   instr_count           retired instructions, wraps modulo 2^CNT_W
//   state                 current FSM state encoding
module r_type_multicycle_controller #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mem_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       function_code,
  output logic             mem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             alu_out_write,
  output logic             reg_write,
  output logic [2:0]       select_bits_ALU,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    StIdle      = 3'b000,
    StFetch     = 3'b001,
    StDecode    = 3'b010,
    StExecute   = 3'b011,
    StWriteback = 3'b100,
    StHalt      = 3'b101,
    StError     = 3'b110
  } state_t;

  localparam logic [5:0] FunctSyscall = 6'b001100;
  // Wait counter value on the last allowed cycle without mem_ready.
  localparam logic [7:0] TimeoutLast  = 8'(TIMEOUT - 1);

  state_t           state_q;
  logic [7:0]       wait_q;
  logic             stop_pend_q;
  logic             mem_req_q;
  logic             alu_out_write_q;
  logic             reg_write_q;
  logic [2:0]       alu_sel_q;
  logic             busy_q;
  logic             halted_q;
  logic             error_q;
  logic [1:0]       err_code_q;
  logic [CNT_W-1:0] instr_count_q;

  logic             funct_legal;
  logic [2:0]       funct_sel;

  always_comb begin
    funct_legal = 1'b1;
    funct_sel   = 3'b000;
    case (function_code)
      6'b100000: funct_sel = 3'b010; // add
      6'b100010: funct_sel = 3'b100; // sub
      6'b100100: funct_sel = 3'b000; // and
      6'b100101: funct_sel = 3'b001; // or
      6'b100111: funct_sel = 3'b111; // nor
      6'b101010: funct_sel = 3'b011; // slt
      6'b000000: funct_sel = 3'b110; // sll
      6'b000010: funct_sel = 3'b101; // srl
      default:   funct_legal = 1'b0;
    endcase
  end

  // Outputs are registered alongside the state so they change with it. The ALU
  // select is captured from the decoded function field on DECODE exit and held
  // through WRITEBACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      wait_q          <= '0;
      stop_pend_q     <= 1'b0;
      mem_req_q       <= 1'b0;
      alu_out_write_q <= 1'b0;
      reg_write_q     <= 1'b0;
      alu_sel_q       <= 3'b000;
      busy_q          <= 1'b0;
      halted_q        <= 1'b0;
      error_q         <= 1'b0;
      err_code_q      <= 2'b00;
      instr_count_q   <= '0;
    end else begin
      alu_out_write_q <= 1'b0;
      reg_write_q     <= 1'b0;
      if (stop && (state_q inside {StFetch, StDecode, StExecute, StWriteback})) begin
        stop_pend_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StFetch;
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            stop_pend_q <= stop; // start wins, stop stays pending
          end
        end
        StFetch: begin
          if (mem_ready) begin
            state_q   <= StDecode;
            mem_req_q <= 1'b0;
            wait_q    <= '0;
          end else if (wait_q == TimeoutLast) begin
            state_q    <= StError;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= 2'b10;
            wait_q     <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StDecode: begin
          if (opcode != 6'b000000) begin
            state_q    <= StError;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= 2'b01;
          end else if (function_code == FunctSyscall) begin
            state_q  <= StHalt;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else if (!funct_legal) begin
            state_q    <= StError;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= 2'b01;
          end else begin
            state_q         <= StExecute;
            alu_out_write_q <= 1'b1;
            alu_sel_q       <= funct_sel;
          end
        end
        StExecute: begin
          state_q     <= StWriteback;
          reg_write_q <= 1'b1;
        end
        StWriteback: begin
          instr_count_q <= instr_count_q + 1'b1;
          alu_sel_q     <= 3'b000;
          if (stop_pend_q || stop) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
          end else begin
            state_q   <= StFetch;
            mem_req_q <= 1'b1;
          end
        end
        StHalt, StError: begin
          // Sticky until reset.
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch capture must coincide with the cycle the word is valid.
  assign ir_write        = (state_q == StFetch) && mem_ready && !reset;
  assign pc_write        = ir_write;
  assign mem_req         = mem_req_q;
  assign alu_out_write   = alu_out_write_q;
  assign reg_write       = reg_write_q;
  assign select_bits_ALU = alu_sel_q;
  assign busy            = busy_q;
  assign halted          = halted_q;
  assign error           = error_q;
  assign err_code        = err_code_q;
  assign instr_count     = instr_count_q;
  assign state           = state_q;

endmodule

// File: tb/tb_r_type_multicycle_controller.sv
module tb_r_type_multicycle_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, start, stop, mem_ready;
  logic [5:0]    opcode, function_code;
  logic          mem_req, ir_write, pc_write, alu_out_write, reg_write;
  logic [2:0]    select_bits_ALU;
  logic          busy, halted, error;
  logic [1:0]    err_code;
  logic [CW-1:0] instr_count;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  logic [5:0] funct_tab [8];
  logic [2:0] sel_tab   [8];

  r_type_multicycle_controller #(.TIMEOUT(15), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mem_ready(mem_ready),
    .opcode(opcode), .function_code(function_code), .mem_req(mem_req),
    .ir_write(ir_write), .pc_write(pc_write), .alu_out_write(alu_out_write),
    .reg_write(reg_write), .select_bits_ALU(select_bits_ALU), .busy(busy),
    .halted(halted), .error(error), .err_code(err_code), .instr_count(instr_count),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; mem_ready = 1'b0;
    opcode = 6'd0; function_code = 6'd0;
    tick();
    reset = 1'b0;
  endtask

  // Start from IDLE and land in FETCH.
  task automatic go_fetch();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 3'b001 || mem_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL go_fetch: state=%b mem_req=%b busy=%b, want 001 1 1", state, mem_req, busy);
    end
  endtask

  // Runs one legal instruction from FETCH (mem_ready on the first cycle) through
  // WRITEBACK and one tick beyond.
  task automatic run_instr(input logic [5:0] fn, input logic [2:0] sel, input bit stop_in_exec);
    opcode = 6'd0; function_code = fn; mem_ready = 1'b1;
    #1;
    checks++;
    if (ir_write !== 1'b1 || pc_write !== 1'b1 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_enables fn=%b: ir=%b pc=%b req=%b, want 1 1 1", fn, ir_write,
               pc_write, mem_req);
    end
    tick();
    mem_ready = 1'b0;
    checks++;
    if (state !== 3'b010 || ir_write !== 1'b0 || pc_write !== 1'b0 || select_bits_ALU !== 3'b000)
    begin
      errors++;
      $display("FAIL decode fn=%b: state=%b ir=%b pc=%b sel=%b, want 010 0 0 000", fn, state,
               ir_write, pc_write, select_bits_ALU);
    end
    tick();
    checks++;
    if (state !== 3'b011 || alu_out_write !== 1'b1 || reg_write !== 1'b0 ||
        select_bits_ALU !== sel) begin
      errors++;
      $display("FAIL execute fn=%b: state=%b aow=%b rw=%b sel=%b, want 011 1 0 %b", fn, state,
               alu_out_write, reg_write, select_bits_ALU, sel);
    end
    if (stop_in_exec) stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (state !== 3'b100 || alu_out_write !== 1'b0 || reg_write !== 1'b1 ||
        select_bits_ALU !== sel) begin
      errors++;
      $display("FAIL writeback fn=%b: state=%b aow=%b rw=%b sel=%b, want 100 0 1 %b", fn, state,
               alu_out_write, reg_write, select_bits_ALU, sel);
    end
    tick();
    checks++;
    if (reg_write !== 1'b0 || select_bits_ALU !== 3'b000) begin
      errors++;
      $display("FAIL after_wb fn=%b: rw=%b sel=%b, want 0 000", fn, reg_write, select_bits_ALU);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_req, ir_write, pc_write, alu_out_write, reg_write, select_bits_ALU, busy, halted,
         error, err_code, state} !== 16'd0 || instr_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: outs=%b cnt=%0d, want all 0",
               {mem_req, ir_write, pc_write, alu_out_write, reg_write, select_bits_ALU, busy,
                halted, error, err_code, state}, instr_count);
    end
  endtask

  task automatic test_add();
    do_reset();
    go_fetch();
    run_instr(6'b100000, 3'b010, 1'b0);
    checks++;
    if (state !== 3'b001 || instr_count !== 4'd1) begin
      errors++;
      $display("FAIL add_retire: state=%b cnt=%0d, want 001 1", state, instr_count);
    end
  endtask

  task automatic test_all_functs();
    do_reset();
    go_fetch();
    for (int i = 0; i < 8; i++) run_instr(funct_tab[i], sel_tab[i], 1'b0);
    opcode = 6'd0; function_code = 6'b001100; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    checks++;
    if (state !== 3'b101 || halted !== 1'b1 || busy !== 1'b0 || instr_count !== 4'd8) begin
      errors++;
      $display("FAIL syscall_halt: state=%b halted=%b busy=%b cnt=%0d, want 101 1 0 8", state,
               halted, busy, instr_count);
    end
    start = 1'b1; mem_ready = 1'b1;
    tick(); tick();
    start = 1'b0; mem_ready = 1'b0;
    checks++;
    if (state !== 3'b101 || mem_req !== 1'b0 || ir_write !== 1'b0 || instr_count !== 4'd8) begin
      errors++;
      $display("FAIL halt_sticky: state=%b req=%b ir=%b cnt=%0d, want 101 0 0 8", state, mem_req,
               ir_write, instr_count);
    end
  endtask

  task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
    bit saw_rw = 1'b0;
    do_reset();
    go_fetch();
    opcode = op; function_code = fn; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (reg_write === 1'b1) saw_rw = 1'b1;
    end
    checks++;
    if (state !== 3'b110 || error !== 1'b1 || err_code !== 2'b01 || saw_rw ||
        instr_count !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal op=%b fn=%b: state=%b err=%b code=%b rw_seen=%b cnt=%0d busy=%b, want 110 1 01 0 0 0",
               op, fn, state, error, err_code, saw_rw, instr_count, busy);
    end
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    do_reset();
    go_fetch();
    mem_ready = 1'b0;
    for (int i = 1; i < 15; i++) begin
      tick();
      if (state !== 3'b001) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL timeout_early: left FETCH before 15 cycles, state=%b", state);
    end
    tick();
    checks++;
    if (state !== 3'b110 || error !== 1'b1 || err_code !== 2'b10 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout: state=%b err=%b code=%b req=%b, want 110 1 10 0", state, error,
               err_code, mem_req);
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (state !== 3'b110 || err_code !== 2'b10) begin
      errors++;
      $display("FAIL error_sticky: state=%b code=%b, want 110 10", state, err_code);
    end
  endtask

  // Waits 10 cycles then 14 cycles on consecutive fetches: the counter must clear.
  task automatic test_back_to_back();
    do_reset();
    go_fetch();
    repeat (10) tick();
    run_instr(6'b100010, 3'b100, 1'b0);
    repeat (14) tick();
    checks++;
    if (state !== 3'b001) begin
      errors++;
      $display("FAIL wait_clear: state=%b, want 001", state);
    end
    run_instr(6'b100101, 3'b001, 1'b0);
    checks++;
    if (instr_count !== 4'd2 || error !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: cnt=%0d err=%b, want 2 0", instr_count, error);
    end
  endtask

  task automatic test_stop();
    do_reset();
    go_fetch();
    run_instr(6'b101010, 3'b011, 1'b1);
    checks++;
    if (state !== 3'b000 || busy !== 1'b0 || instr_count !== 4'd1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL stop_exec: state=%b busy=%b cnt=%0d req=%b, want 000 0 1 0", state, busy,
               instr_count, mem_req);
    end
    stop = 1'b1;
    go_fetch();
    stop = 1'b0;
    run_instr(6'b000000, 3'b110, 1'b0);
    checks++;
    if (state !== 3'b000 || instr_count !== 4'd2) begin
      errors++;
      $display("FAIL start_stop_idle: state=%b cnt=%0d, want 000 2", state, instr_count);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    go_fetch();
    for (int i = 0; i < 15; i++) run_instr(6'b000010, 3'b101, 1'b0);
    checks++;
    if (instr_count !== 4'd15) begin
      errors++;
      $display("FAIL count_15: cnt=%0d, want 15", instr_count);
    end
    run_instr(6'b100111, 3'b111, 1'b0);
    checks++;
    if (instr_count !== 4'd0 || state !== 3'b001) begin
      errors++;
      $display("FAIL count_wrap: cnt=%0d state=%b, want 0 001", instr_count, state);
    end
    repeat (3) tick();
    reset = 1'b1; start = 1'b1; stop = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (ir_write !== 1'b0 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_prio_fetch: ir=%b pc=%b, want 0 0", ir_write, pc_write);
    end
    tick();
    reset = 1'b0; start = 1'b0; stop = 1'b0; mem_ready = 1'b0;
    checks++;
    if ({mem_req, ir_write, pc_write, alu_out_write, reg_write, select_bits_ALU, busy, halted,
         error, err_code, state} !== 16'd0 || instr_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_fetch: outs=%b cnt=%0d, want all 0",
               {mem_req, ir_write, pc_write, alu_out_write, reg_write, select_bits_ALU, busy,
                halted, error, err_code, state}, instr_count);
    end
    tick();
    checks++;
    if (state !== 3'b000) begin
      errors++;
      $display("FAIL idle_hold: state=%b, want 000", state);
    end
  endtask

  initial begin
    funct_tab[0] = 6'b100000; sel_tab[0] = 3'b010;
    funct_tab[1] = 6'b100010; sel_tab[1] = 3'b100;
    funct_tab[2] = 6'b100100; sel_tab[2] = 3'b000;
    funct_tab[3] = 6'b100101; sel_tab[3] = 3'b001;
    funct_tab[4] = 6'b100111; sel_tab[4] = 3'b111;
    funct_tab[5] = 6'b101010; sel_tab[5] = 3'b011;
    funct_tab[6] = 6'b000000; sel_tab[6] = 3'b110;
    funct_tab[7] = 6'b000010; sel_tab[7] = 3'b101;

    test_reset();
    test_add();
    test_all_functs();
    test_illegal(6'b100011, 6'b100000);
    test_illegal(6'b000000, 6'b111111);
    test_timeout();
    test_back_to_back();
    test_stop();
    test_wrap_and_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
